// File: rtl/counter_arb_pkg.sv
// Shared types and constants for counter_arbiter.
// Build option: COUNTER_ARB_RR_EN selects round-robin arbitration (fixed priority otherwise).
package counter_arb_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

    localparam int unsigned NumReqDefault = 4;
    localparam int unsigned WidthDefault  = 4;
    localparam int unsigned MaxReq        = 16;

    // OR-reduction form: cheap, and exact for any one-hot or all-zero input.
    function automatic logic [3:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/counter_arb_pick.sv
// Combinational winner selection for counter_arbiter.
// COUNTER_ARB_RR_EN: round-robin scan from ptr; otherwise lowest pending index wins.
module counter_arb_pick
    import counter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault
) (
    input  logic [NUM_REQ-1:0]         req,
`ifdef COUNTER_ARB_RR_EN
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
`endif
    output logic                       valid,
    output logic [NUM_REQ-1:0]         winner
);

    assign valid = |req;

`ifdef COUNTER_ARB_RR_EN
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] pos;
    logic            found;

    // ptr holds the first index to try, i.e. one past the last grant.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        pos    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IdxW'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[pos]) begin
                winner[pos] = 1'b1;
                found       = 1'b1;
            end
        end
    end
`else
    logic found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/counter_arbiter.sv
// Shares one up-counter among NUM_REQ requesters, one timed interval at a time.
// COUNTER_ARB_RR_EN: round-robin arbitration with a pointer register; else fixed priority.
module counter_arbiter
    import counter_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    parameter int unsigned WIDTH   = WidthDefault
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_len,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [WIDTH-1:0]         count,
    output logic [NUM_REQ-1:0]       done
);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]     count_q, count_d;
    logic [WIDTH-1:0]     len_q, len_d;

    logic                 pick_valid;
    logic [NUM_REQ-1:0]   pick_winner;
    logic [WIDTH-1:0]     win_len;
    logic                 owner_req;
    logic                 at_term;

`ifdef COUNTER_ARB_RR_EN
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] win_idx;

    assign win_idx = IdxW'(onehot_to_idx(MaxReq'(pick_winner)));
`endif

    counter_arb_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req   (req),
`ifdef COUNTER_ARB_RR_EN
        .ptr   (ptr_q),
`endif
        .valid (pick_valid),
        .winner(pick_winner)
    );

    always_comb begin
        win_len = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_winner[i]) begin
                win_len = req_len[i*WIDTH +: WIDTH];
            end
        end
    end

    // Owner is identified by its grant bit, so no separate owner index is kept.
    assign owner_req = |(req & grant_q);
    assign at_term   = (count_q == len_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        count_d = count_q;
        len_d   = len_q;
`ifdef COUNTER_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StRun;
                    grant_d = pick_winner;
                    count_d = '0;
                    len_d   = win_len;
`ifdef COUNTER_ARB_RR_EN
                    ptr_d   = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                end
            end
            StRun: begin
                // Abort and completion both return to idle; only completion pulses done.
                if (!owner_req || at_term) begin
                    state_d = StIdle;
                    grant_d = '0;
                    count_d = '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

`ifdef COUNTER_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign grant = grant_q;
    assign busy  = (state_q == StRun);
    assign count = count_q;
    assign done  = (state_q == StRun && owner_req && at_term) ? grant_q : '0;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
    a_busy_grant:    assert property (@(posedge clk) disable iff (!reset)
                                      busy == (grant != '0));

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter: interval model plus directed literal checks.
module tb_counter_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   count;
    logic [N-1:0]   done;

    int errors = 0;
    int checks = 0;

    counter_arbiter #(
        .NUM_REQ(N),
        .WIDTH  (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .req_len(req_len),
        .grant  (grant),
        .busy   (busy),
        .count  (count),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an interval owner (-1 when idle), its elapsed count and its latched length.
    int m_owner;
    int m_cnt;
    int m_len;
`ifdef COUNTER_ARB_RR_EN
    int m_start;
`endif

    function automatic int model_pick(input logic [N-1:0] r);
`ifdef COUNTER_ARB_RR_EN
        for (int k = 0; k < N; k++) begin
            if (r[(m_start + k) % N]) return (m_start + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int len_of(input int w);
        return int'(req_len[w*W +: W]);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owner <= -1;
            m_cnt   <= 0;
            m_len   <= 0;
`ifdef COUNTER_ARB_RR_EN
            m_start <= 0;
`endif
        end else if (m_owner < 0) begin
            if (req != '0) begin
                m_owner <= model_pick(req);
                m_cnt   <= 0;
                m_len   <= len_of(model_pick(req));
`ifdef COUNTER_ARB_RR_EN
                m_start <= (model_pick(req) + 1) % N;
`endif
            end
        end else if (!req[m_owner] || m_cnt == m_len) begin
            m_owner <= -1;
            m_cnt   <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            if (req[m_owner] && m_cnt == m_len) ed = eg;
        end
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_busy",  32'(busy),  32'(m_owner >= 0));
        chk("model_count", 32'(count), 32'(m_cnt));
        chk("model_done",  32'(done),  32'(ed));
    end

    logic [N-1:0] exp_c [5];

    initial begin
`ifdef COUNTER_ARB_RR_EN
        exp_c = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`else
        exp_c = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`endif
        reset   = 1'b1;
        req     = '0;
        req_len = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_done",  32'(done),  32'h0);
        @(posedge clk); #1 reset = 1'b1;

        // Contention, all lengths 0: a grant every other cycle.
        @(posedge clk); #1 req = 4'b1111; req_len = '0;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("cont_grant", 32'(grant), 32'(exp_c[j]));
            chk("cont_done",  32'(done),  32'(exp_c[j]));
            if (j < 4) begin
                @(negedge clk);
                chk("cont_gap_busy", 32'(busy), 32'h0);
            end
        end
        @(posedge clk); #1 req = '0;
        @(negedge clk);

        // Single request, length 3.
        @(posedge clk); #1 req = 4'b0001; req_len = 16'h0003;
        @(negedge clk);
        chk("single_c0_grant", 32'(grant), 32'h0);
        @(negedge clk);
        chk("single_c1_grant", 32'(grant), 32'h1);
        chk("single_c1_count", 32'(count), 32'h0);
        repeat (2) @(negedge clk);
        chk("single_c3_count", 32'(count), 32'h2);
        @(negedge clk);
        chk("single_c4_count", 32'(count), 32'h3);
        chk("single_c4_done",  32'(done),  32'h1);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        chk("single_c5_grant", 32'(grant), 32'h0);
        chk("single_c5_busy",  32'(busy),  32'h0);

        // Length 0: done alongside count 0.
        @(posedge clk); #1 req = 4'b0100; req_len = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("len0_grant", 32'(grant), 32'h4);
        chk("len0_count", 32'(count), 32'h0);
        chk("len0_done",  32'(done),  32'h4);
        @(posedge clk); #1 req = '0;
        @(negedge clk);

        // Length 15, with a req_len change after the latch that must be ignored.
        @(posedge clk); #1 req = 4'b0010; req_len = 16'h00F0;
        @(negedge clk);
        @(posedge clk); #1 req_len = 16'h0020;
        repeat (16) @(negedge clk);
        chk("len15_count", 32'(count), 32'hF);
        chk("len15_done",  32'(done),  32'h2);
        @(posedge clk); #1 req = '0;
        @(negedge clk);
        chk("len15_after_count", 32'(count), 32'h0);
        chk("len15_after_grant", 32'(grant), 32'h0);

        // Abort of req0 at count 2 of 5, req1 pending.
        @(posedge clk); #1 req = 4'b0001; req_len = 16'h0015;
        @(negedge clk);
        @(posedge clk); #1 req = 4'b0011;
        @(negedge clk);
        chk("abort_c1_grant", 32'(grant), 32'h1);
        @(posedge clk);
        @(posedge clk); #1 req = 4'b0010;
        @(negedge clk);
        chk("abort_c3_count", 32'(count), 32'h2);
        chk("abort_c3_done",  32'(done),  32'h0);
        @(negedge clk);
        chk("abort_c4_busy",  32'(busy),  32'h0);
        chk("abort_c4_count", 32'(count), 32'h0);
        @(negedge clk);
        chk("abort_c5_grant", 32'(grant), 32'h2);
        @(negedge clk);
        chk("abort_c6_done",  32'(done),  32'h2);
        @(posedge clk); #1 req = '0;
        @(negedge clk);

        // Asynchronous reset in the middle of an interval.
        @(posedge clk); #1 req = 4'b1000; req_len = 16'hA000;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("rmid_count_pre", 32'(count), 32'h7);
        #2 reset = 1'b0;
        #1;
        chk("rmid_grant", 32'(grant), 32'h0);
        chk("rmid_busy",  32'(busy),  32'h0);
        chk("rmid_count", 32'(count), 32'h0);
        chk("rmid_done",  32'(done),  32'h0);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rmid_regrant", 32'(grant), 32'h8);
        chk("rmid_recount", 32'(count), 32'h0);
        @(posedge clk); #1 req = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
